// File: rtl/mem.sv
// Memory-access stage: single-outstanding req/ack data port, store lane alignment, load extension, ALU pass-through.
// Latency: pass-through 1 cycle; loads/stores 2+ cycles (request, ack, registered result).
// Backpressure: stall_o holds upstream while an access is accepted or in flight; released on ack or timeout.
module mem #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] instaddr_i,
    input  logic        cs_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_din_i,
    input  logic [31:0] mem_addr_i,
    input  logic        regs_wen_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] rd_data_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_wem_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] instaddr_o,
    output logic        regs_wen_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        misalign_o,
    output logic        bus_err_o
);
    typedef enum logic {IDLE, BUS} state_t;

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          kill;
    logic          p_wen;
    logic [1:0]    p_lo;

    logic [2:0]    f3;
    logic [1:0]    lo;
    logic          misal, accept, timeout, done, killed;
    logic [3:0]    wem_c;
    logic [31:0]   wdata_c, sh, ld_data;

    assign f3      = inst_i[14:12];
    assign lo      = mem_addr_i[1:0];
    assign misal   = (f3[1:0] == 2'b01 && lo[0]) || (f3[1] && lo != 2'b00);
    assign accept  = valid_i && cs_i && !flush_i && !misal;
    assign timeout = (TIMEOUT_CYC != 0) && (state == BUS) && !dmem_ack_i
                     && (cnt == CW'(TIMEOUT_CYC - 1));
    assign done    = (state == BUS) && (dmem_ack_i || timeout);
    assign killed  = kill || flush_i;
    assign wdata_c = mem_din_i << {lo, 3'b000};

    always_comb begin
        wem_c = 4'hF;
        case (f3[1:0])
            2'b00:   wem_c = 4'b0001 << lo;
            2'b01:   wem_c = 4'b0011 << lo;
            default: wem_c = 4'hF;
        endcase
    end

    // Extension uses the size/sign bits captured in inst_o when the access was accepted.
    assign sh = dmem_rdata_i >> {p_lo, 3'b000};
    always_comb begin
        ld_data = dmem_rdata_i;
        case (inst_o[13:12])
            2'b00:   ld_data = {{24{~inst_o[14] & sh[7]}}, sh[7:0]};
            2'b01:   ld_data = {{16{~inst_o[14] & sh[15]}}, sh[15:0]};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        case (state)
            IDLE: if (accept) begin
                stall_o   = 1'b1;
                state_nxt = BUS;
            end
            BUS: begin
                stall_o = !done;
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_wem_o   <= 4'h0;
            dmem_addr_o  <= 32'h0;
            dmem_wdata_o <= 32'h0;
            valid_o      <= 1'b0;
            inst_o       <= 32'h0;
            instaddr_o   <= 32'h0;
            regs_wen_o   <= 1'b0;
            rd_addr_o    <= 5'h0;
            rd_data_o    <= 32'h0;
            misalign_o   <= 1'b0;
            bus_err_o    <= 1'b0;
            cnt          <= '0;
            kill         <= 1'b0;
            p_wen        <= 1'b0;
            p_lo         <= 2'b00;
        end else begin
            valid_o    <= 1'b0;
            regs_wen_o <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            if (state == IDLE) begin
                inst_o     <= inst_i;
                instaddr_o <= instaddr_i;
                rd_addr_o  <= rd_addr_i;
                rd_data_o  <= rd_data_i;
                kill       <= 1'b0;
                cnt        <= '0;
                if (valid_i && !flush_i) begin
                    if (!cs_i) begin
                        valid_o    <= 1'b1;
                        regs_wen_o <= regs_wen_i;
                    end else if (misal) begin
                        valid_o    <= 1'b1;
                        misalign_o <= 1'b1;
                    end else begin
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= mem_we_i;
                        dmem_wem_o   <= mem_we_i ? wem_c : 4'h0;
                        dmem_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        dmem_wdata_o <= wdata_c;
                        p_wen        <= regs_wen_i && !mem_we_i;
                        p_lo         <= lo;
                    end
                end
            end else begin
                kill <= killed;
                if (done) begin
                    // A killed access still finishes on the bus but leaves no trace downstream.
                    dmem_req_o <= 1'b0;
                    dmem_we_o  <= 1'b0;
                    dmem_wem_o <= 4'h0;
                    valid_o    <= !killed;
                    regs_wen_o <= p_wen && dmem_ack_i && !killed;
                    rd_data_o  <= dmem_we_o ? 32'h0 : ld_data;
                    bus_err_o  <= timeout && !killed;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule
